// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding one shared signed 8+8 adder; IDLE -> CALC -> RESP per operation.
// Latency: accept in cycle T, rsp_valid from T+2; one op per 3 cycles; rsp_* hold in RESP until rsp_ready.
module add_arbiter #(
   parameter int N_REQ = 4,
   parameter int SUM_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_a,
   input  logic [8*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [SUM_W-1:0]     rsp_sum,
   output logic [2:0]           rsp_id,
   output logic                 busy,
   output logic [15:0]          op_count
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [2:0]        win_q, win_d;
   logic [7:0]        op_a_q, op_a_d;
   logic [7:0]        op_b_q, op_b_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [SUM_W-1:0]  rsp_sum_q, rsp_sum_d;
   logic [2:0]        rsp_id_q, rsp_id_d;
   logic [15:0]       op_count_q, op_count_d;

   logic [7:0]        valid8;
   logic [3:0]        cand;
   logic              found;
   logic [2:0]        win_idx;
   logic [7:0]        sel_a, sel_b;
   logic [8:0]        sum9;
   logic              grant;

   assign valid8 = 8'(req_valid);

   // Search from ptr upward, wrapping at N_REQ; first valid requester wins.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr_q} + 4'(k);
         if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
         if (!found && valid8[cand[2:0]]) begin
            found   = 1'b1;
            win_idx = cand[2:0];
         end
      end
   end

   assign grant = rst_n && (state_q == IDLE) && found;
   assign busy  = rst_n && (state_q != IDLE);

   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant && (win_idx == 3'(i));
         if (win_idx == 3'(i)) begin
            sel_a = req_a[8*i +: 8];
            sel_b = req_b[8*i +: 8];
         end
      end
   end

   // The single shared adder: 9 bits cover -256..+254 exactly.
   assign sum9 = {op_a_q[7], op_a_q} + {op_b_q[7], op_b_q};

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_id_d    = rsp_id_q;
      op_count_d  = op_count_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               op_a_d  = sel_a;
               op_b_d  = sel_b;
               win_d   = win_idx;
               ptr_d   = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
               state_d = CALC;
            end
         end
         CALC: begin
            rsp_sum_d   = SUM_W'($signed(sum9));
            rsp_id_d    = win_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= '0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_id_q    <= rsp_id_d;
         op_count_q  <= op_count_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: scenario tasks plus a scoreboard of expected {sum,id} popped on each response handshake.
module tb_add_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [8*N-1:0] req_a, req_b;
   logic [N-1:0]  req_ready;
   logic          rsp_valid, rsp_ready;
   logic [31:0]   rsp_sum;
   logic [2:0]    rsp_id;
   logic          busy;
   logic [15:0]   op_count;

   int            checks = 0;
   int            errors = 0;
   logic [15:0]   exp_count = '0;

   typedef struct packed {
      logic [31:0] sum;
      logic [2:0]  id;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   add_arbiter #(.N_REQ(N), .SUM_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
      .busy(busy), .op_count(op_count)
   );

   function automatic exp_t mk(input int id, input int a, input int b);
      exp_t e;
      e.sum = 32'(a + b);
      e.id  = 3'(id);
      return e;
   endfunction

   // Scoreboard: pop and compare on every accepted response.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got sum=%0h id=%0d, expected no response", rsp_sum, rsp_id);
         end else begin
            mon_e = sb.pop_front();
            if (rsp_sum !== mon_e.sum || rsp_id !== mon_e.id) begin
               errors++;
               $display("FAIL rsp_data: got sum=%0h id=%0d, expected sum=%0h id=%0d",
                        rsp_sum, rsp_id, mon_e.sum, mon_e.id);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      req_a[8*i +: 8] = 8'(a);
      req_b[8*i +: 8] = 8'(b);
   endtask

   task automatic wait_rsp();
      bit seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: rsp_valid=%b, expected 1 within 10 cycles", rsp_valid);
      end
   endtask

   task automatic drain();
      bit done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && busy === 1'b0) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending=%0d busy=%b, expected 0 and 0", sb.size(), busy);
      end
   endtask

   // Drives one isolated request (DUT idle, rsp_ready=1) and returns the grant vector seen.
   task automatic run_op(input int i, input int a, input int b, output logic [N-1:0] g);
      tick();
      req_valid = 4'(1 << i);
      set_ops(i, a, b);
      sb.push_back(mk(i, a, b));
      @(negedge clk);
      g = req_ready;
      tick();
      req_valid = '0;
      wait_rsp();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      req_a = '0;
      req_b = '0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req_ready=%b busy=%b, expected 0000 0", req_ready, busy);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_id !== 3'd0 || op_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b sum=%0h id=%0d cnt=%0d, expected 0 0 0 0",
                  rsp_valid, rsp_sum, rsp_id, op_count);
      end
      tick();
      req_valid = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      tick();
      req_valid = 4'b0001;
      set_ops(0, 100, 27);
      sb.push_back(mk(0, 100, 27));
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_grant: req_ready=%b busy=%b, expected 0001 0", req_ready, busy);
      end
      tick();
      req_valid = '0;
      req_a = '1;
      req_b = '1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL single_calc: valid=%b busy=%b ready=%b, expected 0 1 0000", rsp_valid, busy, req_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: rsp_valid=%b at T+2, expected 1", rsp_valid);
      end
      tick();
      @(negedge clk);
      exp_count++;
      checks++;
      if (op_count !== exp_count || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done: cnt=%0d valid=%b busy=%b, expected %0d 0 0",
                  op_count, rsp_valid, busy, exp_count);
      end
   endtask

   task automatic test_extremes();
      logic [N-1:0] g;
      run_op(2, -128, -128, g);
      checks++;
      if (g !== 4'b0100) begin
         errors++;
         $display("FAIL extreme_neg_grant: req_ready=%b, expected 0100", g);
      end
      run_op(3, 127, 127, g);
      checks++;
      if (g !== 4'b1000) begin
         errors++;
         $display("FAIL extreme_pos_grant: req_ready=%b, expected 1000", g);
      end
      @(negedge clk);
      exp_count += 16'd2;
      checks++;
      if (op_count !== exp_count) begin
         errors++;
         $display("FAIL extreme_count: op_count=%0d, expected %0d", op_count, exp_count);
      end
   endtask

   task automatic test_round_robin();
      int gap;
      bit hit;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = '0;
      for (int i = 0; i < N; i++) set_ops(i, i * 20 - 30, i * 7 + 5);
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int g = 0; g < 2 * N; g++) begin
         gap = 0;
         hit = 0;
         for (int c = 0; c < 6 && !hit; c++) begin
            @(negedge clk);
            gap++;
            if (req_ready !== 4'b0000) hit = 1;
         end
         checks++;
         if (req_ready !== 4'(1 << (g % N))) begin
            errors++;
            $display("FAIL rr_order: grant %0d req_ready=%b, expected %b", g, req_ready, 4'(1 << (g % N)));
         end
         sb.push_back(mk(g % N, (g % N) * 20 - 30, (g % N) * 7 + 5));
         if (g > 0) begin
            checks++;
            if (gap !== 3) begin
               errors++;
               $display("FAIL rr_throughput: grant %0d gap=%0d cycles, expected 3", g, gap);
            end
         end
      end
      tick();
      req_valid = '0;
      drain();
      exp_count += 16'(2 * N);
      checks++;
      if (op_count !== exp_count) begin
         errors++;
         $display("FAIL rr_count: op_count=%0d, expected %0d", op_count, exp_count);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      e = mk(1, -5, -9);
      rsp_ready = 1'b0;
      tick();
      req_valid = 4'b0010;
      set_ops(1, -5, -9);
      set_ops(0, 1, 1);
      sb.push_back(e);
      tick();
      req_valid = 4'b0011;
      wait_rsp();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_sum !== e.sum || rsp_id !== e.id || req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%b sum=%0h id=%0d ready=%b busy=%b, expected 1 %0h %0d 0000 1",
                     k, rsp_valid, rsp_sum, rsp_id, req_ready, busy, e.sum, e.id);
         end
      end
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = '0;
      @(negedge clk);
      exp_count++;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== exp_count) begin
         errors++;
         $display("FAIL bp_release: busy=%b valid=%b cnt=%0d, expected 0 0 %0d", busy, rsp_valid, op_count, exp_count);
      end
   endtask

   task automatic test_drop_valid();
      bit bad = 0;
      rsp_ready = 1'b0;
      tick();
      req_valid = 4'b0001;
      set_ops(0, 60, -61);
      sb.push_back(mk(0, 60, -61));
      tick();
      req_valid = 4'b0100;
      set_ops(2, 9, 9);
      tick();
      tick();
      req_valid = '0;
      wait_rsp();
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (req_ready !== 4'b0000 || busy !== 1'b0) bad = 1;
      end
      exp_count++;
      checks++;
      if (bad || op_count !== exp_count || sb.size() != 0) begin
         errors++;
         $display("FAIL drop_valid: stray_grant=%0d cnt=%0d pending=%0d, expected 0 %0d 0",
                  bad, op_count, sb.size(), exp_count);
      end
   endtask

   task automatic test_reset_in_resp();
      rsp_ready = 1'b0;
      tick();
      req_valid = 4'b0010;
      set_ops(1, 50, 50);
      tick();
      req_valid = '0;
      wait_rsp();
      tick();
      rst_n = 1'b0;
      req_valid = 4'b1001;
      set_ops(0, -100, 33);
      set_ops(3, 11, 22);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_hold: req_ready=%b busy=%b, expected 0000 0", req_ready, busy);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      exp_count = '0;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_id !== 3'd0 || op_count !== exp_count) begin
         errors++;
         $display("FAIL rst_resp: valid=%b sum=%0h id=%0d cnt=%0d, expected 0 0 0 0",
                  rsp_valid, rsp_sum, rsp_id, op_count);
      end
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_ptr: req_ready=%b, expected 0001", req_ready);
      end
      sb.push_back(mk(0, -100, 33));
      rsp_ready = 1'b1;
      tick();
      req_valid = '0;
      drain();
      exp_count++;
      checks++;
      if (op_count !== exp_count) begin
         errors++;
         $display("FAIL rst_after_count: op_count=%0d, expected %0d", op_count, exp_count);
      end
   endtask

   task automatic test_wrap();
      logic [N-1:0] g;
      rsp_ready = 1'b1;
      @(negedge clk);
      force dut.op_count_q = 16'hFFFD;
      #1;
      release dut.op_count_q;
      exp_count = 16'hFFFD;
      for (int k = 0; k < 3; k++) begin
         run_op(k, k - 3, 4 - k, g);
         @(negedge clk);
         exp_count++;
         checks++;
         if (op_count !== exp_count) begin
            errors++;
            $display("FAIL wrap_count: step %0d op_count=%h, expected %h", k, op_count, exp_count);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_extremes();
      test_round_robin();
      test_backpressure();
      test_drop_valid();
      test_reset_in_resp();
      test_wrap();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
